// File: rtl/apple2_artifact_video_gen_if.sv
// rtl/apple2_artifact_video_gen_if.sv - video generator to artifact decoder/VGA timing bundle
interface apple2_artifact_video_gen_if #(
  parameter int COLOR_BITS = 8
);
  logic                  VIDEO;
  logic                  COLOR_LINE;
  logic [1:0]            SCREEN_MODE;
  logic                  HBL;
  logic                  VBL;
  logic                  VGA_HS;
  logic                  VGA_VS;
  logic                  VGA_HBL;
  logic                  VGA_VBL;
  logic [COLOR_BITS-1:0] VGA_R;
  logic [COLOR_BITS-1:0] VGA_G;
  logic [COLOR_BITS-1:0] VGA_B;

  modport master (
    output VIDEO, COLOR_LINE, SCREEN_MODE, HBL, VBL,
    input  VGA_HS, VGA_VS, VGA_HBL, VGA_VBL, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    input  VIDEO, COLOR_LINE, SCREEN_MODE, HBL, VBL,
    output VGA_HS, VGA_VS, VGA_HBL, VGA_VBL, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/apple2_artifact_video_gen.sv
// rtl/apple2_artifact_video_gen.sv - Apple ][ artifact-colour decoder and VGA sync generator
module apple2_artifact_video_gen #(
  parameter int COLOR_BITS  = 8,
  parameter int HSYNC_START = 694,
  parameter int HSYNC_LEN   = 68,
  parameter int VSYNC_LINE  = 33,
  parameter int VSYNC_LINES = 3,
  parameter int HBL_DELAY   = 9,
  parameter int HBL_TRIM    = 8
) (
  input logic                    CLK_14M,
  input logic                    RESET_N,
  apple2_artifact_video_gen_if.slave vid
);
  localparam int          HBL_TAPS = HBL_DELAY + HBL_TRIM + 1;
  localparam logic [10:0] HS_ON    = 11'(HSYNC_START);
  localparam logic [10:0] HS_OFF   = 11'(HSYNC_START + HSYNC_LEN);
  localparam logic [5:0]  VS_ON    = 6'(VSYNC_LINE);
  localparam logic [5:0]  VS_OFF   = 6'(VSYNC_LINE + VSYNC_LINES);
  // NTSC basis colours, entry 0 in the low byte
  localparam logic [31:0] BASIS_R  = 32'h70_08_37_50;
  localparam logic [31:0] BASIS_G  = 32'h07_2C_94_38;
  localparam logic [31:0] BASIS_B  = 32'h07_B0_10_38;

  logic                last_hbl;
  logic [10:0]         hcount;
  logic [5:0]          vcount;
  logic                line_mono;
  logic [1:0]          line_mode;
  logic [5:0]          shift;
  logic [HBL_TAPS-1:0] hbl_pipe;
  logic                hs_q, vs_q, vbl_q;
  logic [7:0]          r_q, g_q, b_q;
  logic [7:0]          bg_r, bg_g, bg_b, fg_r, fg_g, fg_b;
  logic [7:0]          pix_r, pix_g, pix_b;
  logic                line_start;
  logic                stable;

  assign line_start = last_hbl & ~vid.HBL;

  function automatic logic [7:0] mix(input logic [7:0] bg, input logic [31:0] tbl,
                                     input logic [1:0] p, input logic [3:0] s);
    logic [8:0] acc;
    logic [1:0] idx;
    acc = {1'b0, bg};
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k + 1);
      if (s[k]) acc = acc + {1'b0, tbl[8*idx +: 8]};
    end
    return acc[8] ? 8'hFF : acc[7:0];
  endfunction

  always_comb begin
    {bg_r, bg_g, bg_b} = 24'h000000;
    {fg_r, fg_g, fg_b} = 24'hFFFFFF;
    {pix_r, pix_g, pix_b} = 24'h000000;
    case (line_mode)
      2'b10: begin {bg_r, bg_g, bg_b} = 24'h000F01; {fg_r, fg_g, fg_b} = 24'h00C001; end
      2'b11: begin {bg_r, bg_g, bg_b} = 24'h200801; {fg_r, fg_g, fg_b} = 24'hFF8001; end
      default: ;
    endcase
    // A repeating 4-bit pattern means a steady chroma phase; anything else is an edge
    stable = (shift[0] == shift[4]) && (shift[1] == shift[5]);
    if (line_mono) begin
      {pix_r, pix_g, pix_b} = shift[2] ? {fg_r, fg_g, fg_b} : {bg_r, bg_g, bg_b};
    end else if (stable) begin
      pix_r = mix(bg_r, BASIS_R, hcount[1:0], shift[4:1]);
      pix_g = mix(bg_g, BASIS_G, hcount[1:0], shift[4:1]);
      pix_b = mix(bg_b, BASIS_B, hcount[1:0], shift[4:1]);
    end else begin
      case (shift[3:2])
        2'b11:   {pix_r, pix_g, pix_b} = 24'hFFFFFF;
        2'b00:   {pix_r, pix_g, pix_b} = 24'h000000;
        default: {pix_r, pix_g, pix_b} = 24'h808080;
      endcase
    end
  end

  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      last_hbl  <= 1'b0;
      hcount    <= 11'd0;
      vcount    <= 6'd0;
      line_mono <= 1'b0;
      line_mode <= 2'b00;
      shift     <= 6'd0;
      hbl_pipe  <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      vbl_q     <= 1'b0;
      r_q       <= 8'd0;
      g_q       <= 8'd0;
      b_q       <= 8'd0;
    end else begin
      last_hbl <= vid.HBL;
      hbl_pipe <= {hbl_pipe[HBL_TAPS-2:0], last_hbl};
      if (line_start) begin
        hcount    <= 11'd0;
        vbl_q     <= vid.VBL;
        line_mono <= vid.COLOR_LINE | (vid.SCREEN_MODE != 2'b00);
        line_mode <= vid.SCREEN_MODE;
        if (!vid.VBL)               vcount <= 6'd0;
        else if (vcount != 6'd63)   vcount <= vcount + 6'd1;
      end else if (hcount != 11'd2047) begin
        hcount <= hcount + 11'd1;
      end
      if (hcount == HS_ON) begin
        hs_q <= 1'b1;
        if (vcount == VS_ON)  vs_q <= 1'b1;
        if (vcount == VS_OFF) vs_q <= 1'b0;
      end
      if (hcount == HS_OFF) hs_q <= 1'b0;
      // The sync-start clear restarts the artifact window for the next line
      shift <= (hcount == HS_ON) ? 6'd0 : {vid.VIDEO, shift[5:1]};
      r_q   <= pix_r;
      g_q   <= pix_g;
      b_q   <= pix_b;
    end
  end

  assign vid.VGA_HS  = hs_q;
  assign vid.VGA_VS  = vs_q;
  assign vid.VGA_VBL = vbl_q;
  assign vid.VGA_HBL = hbl_pipe[HBL_DELAY] & hbl_pipe[HBL_DELAY+HBL_TRIM];
  assign vid.VGA_R   = r_q[7 -: COLOR_BITS];
  assign vid.VGA_G   = g_q[7 -: COLOR_BITS];
  assign vid.VGA_B   = b_q[7 -: COLOR_BITS];
endmodule
